// File: rtl/pbkdf2_f_iter_if.sv
// Bus bundle for the PBKDF2 block-function engine: job request/result and
// the request/response channels towards hmac_sha256.
interface pbkdf2_f_iter_if;
  logic [511:0] key_i;
  logic [511:0] salt_i;
  logic [5:0]   salt_len_i;
  logic [31:0]  blk_idx_i;
  logic [31:0]  iter_i;
  logic         v_i;
  logic         r_o;

  logic [255:0] dk_o;
  logic         err_o;
  logic         v_o;
  logic         r_i;

  logic [511:0] hmac_key_o;
  logic [511:0] hmac_msg_o;
  logic [5:0]   hmac_len_o;
  logic         hmac_v_o;
  logic         hmac_r_i;

  logic [255:0] hmac_prf_i;
  logic         hmac_v_i;
  logic         hmac_r_o;

  logic [31:0]  iter_cnt_o;

  modport slave (
    input  key_i, salt_i, salt_len_i, blk_idx_i, iter_i, v_i, r_i,
    input  hmac_r_i, hmac_prf_i, hmac_v_i,
    output r_o, dk_o, err_o, v_o,
    output hmac_key_o, hmac_msg_o, hmac_len_o, hmac_v_o, hmac_r_o, iter_cnt_o
  );

  modport master (
    output key_i, salt_i, salt_len_i, blk_idx_i, iter_i, v_i, r_i,
    output hmac_r_i, hmac_prf_i, hmac_v_i,
    input  r_o, dk_o, err_o, v_o,
    input  hmac_key_o, hmac_msg_o, hmac_len_o, hmac_v_o, hmac_r_o, iter_cnt_o
  );
endinterface

// File: rtl/pbkdf2_f_iter.sv
// PBKDF2-HMAC-SHA256 block function T_i = U_1 ^ ... ^ U_c, issuing one HMAC
// request per iteration and XOR-accumulating the returned PRF values.
//
// state | meaning
// IDLE  | ready for a job (r_o high)
// ISSUE | HMAC request valid, key/msg/len held stable
// WAIT  | ready for the HMAC response
// DONE  | result valid until r_i
module pbkdf2_f_iter #(
  parameter int unsigned MAX_SALT_BYTES = 51
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  pbkdf2_f_iter_if.slave  bus
);
  localparam logic [5:0] SALT_MAX = 6'(MAX_SALT_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e       state_q, state_d;
  logic [511:0] key_q, key_d;
  logic [511:0] msg_q, msg_d;
  logic [5:0]   len_q, len_d;
  logic [31:0]  iter_q, iter_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [255:0] acc_q, acc_d;
  logic [255:0] dk_q, dk_d;
  logic         err_q, err_d;
  logic         r_q, v_q, hmac_v_q, hmac_r_q;

  logic         job_xfer, req_xfer, rsp_xfer, done_xfer;
  logic [8:0]   shamt;
  logic [511:0] idx_shifted;
  logic [31:0]  cnt_inc;

  // Handshake flags are registered copies of the state so they read 0 in reset.
  assign job_xfer  = r_q & bus.v_i;
  assign req_xfer  = hmac_v_q & bus.hmac_r_i;
  assign rsp_xfer  = hmac_r_q & bus.hmac_v_i;
  assign done_xfer = v_q & bus.r_i;

  assign shamt       = {bus.salt_len_i, 3'b000};
  assign idx_shifted = {bus.blk_idx_i, 480'b0} >> shamt;
  assign cnt_inc     = cnt_q + 32'd1;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    msg_d   = msg_q;
    len_d   = len_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dk_d    = dk_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (job_xfer) begin
          key_d  = bus.key_i;
          iter_d = (bus.iter_i == 32'd0) ? 32'd1 : bus.iter_i;
          cnt_d  = 32'd0;
          if (bus.salt_len_i > SALT_MAX) begin
            err_d   = 1'b1;
            dk_d    = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            msg_d   = bus.salt_i | idx_shifted;
            len_d   = bus.salt_len_i + 6'd4;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_xfer) state_d = WAIT;
      end
      WAIT: begin
        if (rsp_xfer) begin
          acc_d = (cnt_q == 32'd0) ? bus.hmac_prf_i : (acc_q ^ bus.hmac_prf_i);
          cnt_d = cnt_inc;
          msg_d = {bus.hmac_prf_i, 256'b0};
          len_d = 6'd32;
          if (cnt_inc == iter_q) begin
            dk_d    = acc_d;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (done_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      key_q    <= '0;
      msg_q    <= '0;
      len_q    <= '0;
      iter_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      dk_q     <= '0;
      err_q    <= 1'b0;
      r_q      <= 1'b0;
      v_q      <= 1'b0;
      hmac_v_q <= 1'b0;
      hmac_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      msg_q    <= msg_d;
      len_q    <= len_d;
      iter_q   <= iter_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dk_q     <= dk_d;
      err_q    <= err_d;
      r_q      <= (state_d == IDLE);
      v_q      <= (state_d == DONE);
      hmac_v_q <= (state_d == ISSUE);
      hmac_r_q <= (state_d == WAIT);
    end
  end

  assign bus.r_o        = r_q;
  assign bus.v_o        = v_q;
  assign bus.dk_o       = dk_q;
  assign bus.err_o      = err_q;
  assign bus.hmac_key_o = key_q;
  assign bus.hmac_msg_o = msg_q;
  assign bus.hmac_len_o = len_q;
  assign bus.hmac_v_o   = hmac_v_q;
  assign bus.hmac_r_o   = hmac_r_q;
  assign bus.iter_cnt_o = cnt_q;
endmodule

// File: tb/tb_pbkdf2_f_iter.sv
// Directed bench for pbkdf2_f_iter with a table-driven HMAC stub that can
// insert random ready/valid stalls.
module tb_pbkdf2_f_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pbkdf2_f_iter_if bus ();

  pbkdf2_f_iter #(.MAX_SALT_BYTES(51)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  localparam logic [255:0] U1  = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] DK2 = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [511:0] KEY_PW = {"password", 448'b0};
  localparam logic [511:0] SALT_S = {"salt", 480'b0};

  int n_cmp = 0;
  int n_fail = 0;

  // HMAC stub state
  int unsigned  max_stall = 0;
  int           req_cnt = 0, resp_cnt = 0, req_base = 0, resp_base = 0;
  logic         pending = 1'b0;
  logic [255:0] prf_tab [0:7];
  logic [511:0] req_msg [0:7];
  logic [5:0]   req_len [0:7];
  logic [511:0] req_key [0:7];
  int           mon_idx;

  always @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else begin
      mon_idx = req_cnt - req_base;
      if (bus.hmac_v_o && bus.hmac_r_i) begin
        if (mon_idx >= 0 && mon_idx < 8) begin
          req_msg[mon_idx[2:0]] <= bus.hmac_msg_o;
          req_len[mon_idx[2:0]] <= bus.hmac_len_o;
          req_key[mon_idx[2:0]] <= bus.hmac_key_o;
        end
        req_cnt <= req_cnt + 1;
        pending <= 1'b1;
      end
      if (bus.hmac_v_i && bus.hmac_r_o) begin
        resp_cnt <= resp_cnt + 1;
        pending  <= 1'b0;
      end
    end
  end

  initial begin
    int   stall, dly, ridx;
    logic was_pending;
    stall = 0; dly = 0; was_pending = 1'b0;
    bus.hmac_r_i = 1'b0; bus.hmac_v_i = 1'b0; bus.hmac_prf_i = '0;
    forever begin
      @(negedge clk);
      if (pending && !was_pending) dly = int'($urandom_range(max_stall, 0));
      if (!pending && was_pending) stall = int'($urandom_range(max_stall, 0));
      was_pending = pending;
      if (!pending) begin
        bus.hmac_v_i = 1'b0;
        bus.hmac_r_i = (stall == 0);
        if (stall > 0) stall--;
      end else begin
        bus.hmac_r_i = 1'b0;
        if (!bus.hmac_v_i) begin
          if (dly == 0) begin
            ridx = resp_cnt - resp_base;
            bus.hmac_v_i   = 1'b1;
            bus.hmac_prf_i = prf_tab[ridx[2:0]];
          end else begin
            dly--;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [511:0] k, input logic [511:0] s, input logic [5:0] sl,
                           input logic [31:0] idx, input logic [31:0] it);
    int n = 0;
    while (!bus.r_o && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", bus.r_o, 1);
    req_base = req_cnt; resp_base = resp_cnt;
    bus.key_i = k; bus.salt_i = s; bus.salt_len_i = sl;
    bus.blk_idx_i = idx; bus.iter_i = it; bus.v_i = 1'b1;
    @(negedge clk);
    bus.v_i = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [255:0] exp_dk, input logic exp_err,
                             input logic [31:0] exp_cnt, input int exp_lat, input int hold);
    int n = 0;
    while (!bus.v_o && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_v_o"}, bus.v_o, 1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 512'(n), 512'(exp_lat));
    chk({tag, "_dk"}, bus.dk_o, exp_dk);
    chk({tag, "_err"}, bus.err_o, exp_err);
    chk({tag, "_iter_cnt"}, bus.iter_cnt_o, exp_cnt);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, bus.v_o, 1);
      chk({tag, "_hold_dk"}, bus.dk_o, exp_dk);
    end
    bus.r_i = 1'b1;
    @(negedge clk);
    bus.r_i = 1'b0;
    chk({tag, "_v_drop"}, bus.v_o, 0);
  endtask

  initial begin
    logic [255:0] exp_x;
    int n;
    bus.v_i = 1'b0; bus.r_i = 1'b0; bus.key_i = '0; bus.salt_i = '0;
    bus.salt_len_i = '0; bus.blk_idx_i = '0; bus.iter_i = '0;
    for (int i = 0; i < 8; i++) prf_tab[i] = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_handshake", {bus.r_o, bus.v_o, bus.err_o, bus.hmac_v_o, bus.hmac_r_o}, 0);
    chk("rst_dk", bus.dk_o, 0);
    chk("rst_cnt_len", {bus.iter_cnt_o, bus.hmac_len_o}, 0);
    chk("rst_key_msg", {bus.hmac_key_o ^ bus.hmac_msg_o}, 0);
    chk("rst_msg", bus.hmac_msg_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_r_o", bus.r_o, 1);

    // single iteration, RFC 6070-style vector
    prf_tab[0] = U1;
    start_job(KEY_PW, SALT_S, 6'd4, 32'd1, 32'd1);
    wait_result("c1", U1, 1'b0, 32'd1, 2, 0);
    chk("c1_nreq", 512'(req_cnt - req_base), 1);
    chk("c1_msg", req_msg[0], {"salt", 32'd1, 448'b0});
    chk("c1_len", req_len[0], 8);
    chk("c1_key", req_key[0], KEY_PW);

    // two iterations
    prf_tab[0] = U1;
    prf_tab[1] = U1 ^ DK2;
    start_job(KEY_PW, SALT_S, 6'd4, 32'd1, 32'd2);
    wait_result("c2", DK2, 1'b0, 32'd2, 4, 0);
    chk("c2_nreq", 512'(req_cnt - req_base), 2);
    chk("c2_len2", req_len[1], 32);
    chk("c2_msg2", req_msg[1], {U1, 256'b0});

    // random stalls, c=5, result held 20 cycles against r_i low
    max_stall = 7;
    prf_tab[0] = {8{32'h0123_4567}};
    prf_tab[1] = {8{32'h89ab_cdef}};
    prf_tab[2] = {4{64'hdead_beef_0bad_f00d}};
    prf_tab[3] = {2{128'h5555_aaaa_3333_cccc_0f0f_f0f0_1234_8765}};
    prf_tab[4] = 256'h1;
    exp_x = '0;
    for (int i = 0; i < 5; i++) exp_x ^= prf_tab[i];
    start_job(KEY_PW, SALT_S, 6'd4, 32'd7, 32'd5);
    wait_result("c5", exp_x, 1'b0, 32'd5, -1, 20);
    chk("c5_nreq", 512'(req_cnt - req_base), 5);

    // iter_i = 0 behaves as 1
    prf_tab[0] = {16{16'hbeef}};
    start_job(KEY_PW, SALT_S, 6'd4, 32'd3, 32'd0);
    wait_result("c0", {16{16'hbeef}}, 1'b0, 32'd1, -1, 0);
    repeat (10) @(negedge clk);
    chk("c0_nreq", 512'(req_cnt - req_base), 1);

    // salt length boundaries
    max_stall = 0;
    prf_tab[0] = {32{8'h3c}};
    start_job(KEY_PW, {{51{8'ha5}}, 104'b0}, 6'd51, 32'hdeadbeef, 32'd1);
    wait_result("s51", {32{8'h3c}}, 1'b0, 32'd1, 2, 0);
    chk("s51_len", req_len[0], 55);
    chk("s51_msg", req_msg[0], {{51{8'ha5}}, 32'hdeadbeef, 72'b0});

    start_job(KEY_PW, {{52{8'ha5}}, 96'b0}, 6'd52, 32'd1, 32'd1);
    wait_result("s52", 256'b0, 1'b1, 32'd0, 0, 0);
    repeat (5) @(negedge clk);
    chk("s52_nreq", 512'(req_cnt - req_base), 0);

    // reset while waiting on the third response
    start_job(KEY_PW, SALT_S, 6'd4, 32'd1, 32'd5);
    n = 0;
    while (!((req_cnt - req_base) == 3 && bus.hmac_r_o) && n < 200) begin @(negedge clk); n++; end
    chk("midrst_reach_wait3", bus.hmac_r_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_handshake", {bus.r_o, bus.v_o, bus.err_o, bus.hmac_v_o, bus.hmac_r_o}, 0);
    chk("midrst_cnt", bus.iter_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_r_o", bus.r_o, 1);
    chk("midrst_no_v_o", bus.v_o, 0);

    // back-to-back jobs
    prf_tab[0] = {8{32'hface_0001}};
    start_job(KEY_PW, SALT_S, 6'd4, 32'd1, 32'd1);
    wait_result("b2b1", {8{32'hface_0001}}, 1'b0, 32'd1, 2, 0);
    prf_tab[0] = {8{32'hface_0002}};
    chk("b2b_ready_next_cycle", bus.r_o, 1);
    start_job(KEY_PW, SALT_S, 6'd4, 32'd2, 32'd1);
    chk("b2b_accepted", bus.r_o, 0);
    wait_result("b2b2", {8{32'hface_0002}}, 1'b0, 32'd1, 2, 0);
    chk("b2b2_msg", req_msg[0], {"salt", 32'd2, 448'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pbkdf2_f_iter.md
# pbkdf2_f_iter

PBKDF2-HMAC-SHA256 block-function engine. It computes one 256-bit output block T_i = U_1 ^ U_2 ^ … ^ U_c, where U_1 = HMAC(P, S || INT(i)) and U_j = HMAC(P, U_{j-1}). It sits directly upstream of `hmac_sha256`: it builds every HMAC request (key, left-aligned message, byte length), consumes each PRF result, and XOR-accumulates the results until the iteration count is reached.

## Interface

Parameters:
- `MAX_SALT_BYTES`, default 51. Largest accepted salt length; salt plus 4-byte INT(i) must fit the 55-byte single-block HMAC message.

Ports:
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `key_i` input 512: password, left aligned, zero filled on the right.
- `salt_i` input 512: salt, left aligned, zero filled on the right.
- `salt_len_i` input 6: salt length in bytes.
- `blk_idx_i` input 32: block index i, big-endian INT(i).
- `iter_i` input 32: iteration count c; a value of 0 is treated as 1.
- `v_i` input 1 / `r_o` output 1: job request handshake.
- `dk_o` output 256: T_i result.
- `err_o` output 1: job rejected because of salt length.
- `v_o` output 1 / `r_i` input 1: result handshake.
- `hmac_key_o` output 512: key to `hmac_sha256`.
- `hmac_msg_o` output 512: message to `hmac_sha256`, left aligned.
- `hmac_len_o` output 6: message length in bytes.
- `hmac_v_o` output 1 / `hmac_r_i` input 1: HMAC request handshake.
- `hmac_prf_i` input 256 / `hmac_v_i` input 1 / `hmac_r_o` output 1: HMAC response handshake.
- `iter_cnt_o` output 32: number of completed HMAC iterations in the current job.

## Operation

States are IDLE, ISSUE, WAIT and DONE.

- **Transfers:** a transfer occurs on a rising edge where valid and ready are both high.
- **IDLE**
  - `r_o`=1.
  - On a job transfer: register the key, `iter_q`=max(`iter_i`,1) and `cnt`=0.
  - If `salt_len_i` > `MAX_SALT_BYTES`: go to DONE with `err_o`=1 and `dk_o`=0. No HMAC request is made.
  - Otherwise:
    - `msg_q` = `salt_i` | ({`blk_idx_i`, 480'b0} >> 8·`salt_len_i`).
    - `len_q` = `salt_len_i`+4.
    - Go to ISSUE.
- **ISSUE**
  - `hmac_v_o`=1.
  - `hmac_key_o`, `hmac_msg_o` and `hmac_len_o` are driven from registers and stay stable while `hmac_v_o` is high.
  - On `hmac_r_i`: go to WAIT.
- **WAIT**
  - `hmac_r_o`=1.
  - On `hmac_v_i`:
    - `acc` = (`cnt`==0) ? `hmac_prf_i` : `acc` ^ `hmac_prf_i`.
    - `cnt`++.
    - `msg_q` = {`hmac_prf_i`, 256'b0} and `len_q`=32.
  - If the new `cnt`==`iter_q`: go to DONE. Otherwise go to ISSUE.
- **DONE**
  - `v_o`=1, `dk_o`=`acc`.
  - On `r_i`: go to IDLE. `dk_o` holds its value until the next job completes.
- **Arithmetic:**
  - `cnt` is 32-bit and cannot wrap, because `iter_q` ≤ 2^32−1.
  - The XOR is a full 256-bit bitwise XOR.
  - The INT(i) shift is a logical right shift by a byte count in 0..51.
- **Inputs outside IDLE:** `v_i` is ignored in every state other than IDLE; `r_o`=0 there.
- **Unexpected responses:** a `hmac_v_i` pulse outside WAIT is ignored.

## Timing

- **Reset values** (`rst_ni`=0 sampled on an edge): state=IDLE.
  - `r_o`, `v_o`, `err_o`, `hmac_v_o` and `hmac_r_o` are all 0 while `rst_ni` is low.
  - `dk_o`, `iter_cnt_o`, `hmac_key_o`, `hmac_msg_o` and `hmac_len_o` are all 0.
  - `r_o` rises in the first cycle with `rst_ni`=1.
- **Reset mid-job:** the job is abandoned and no `v_o` is produced. `hmac_sha256` shares this reset, with polarity adapted at the top level, so no in-flight response survives.
- **Latency:**
  - Accept edge → `hmac_v_o` high in the next cycle.
  - Response edge → next `hmac_v_o` high in the next cycle, so there is 1 bubble cycle per iteration.
  - Final response edge → `v_o` high in the next cycle.
  - Total is c·(L_hmac+2)+1 cycles when all ready signals are held high.
- **Handshake rules:**
  - All outputs are registered or decoded from state only, with no combinational path from input to output.
  - `v_o` stays high until `r_i`; `dk_o` is stable while `v_o` is high.
  - `r_i` held low indefinitely stalls in DONE with no loss of data.
- **Back-to-back jobs:** a job may be accepted in the cycle after the DONE→IDLE transfer.

## Test plan

- **Single iteration, real `hmac_sha256`:** P="password", S="salt" (`salt_len_i`=4), i=1, c=1 → `dk_o`=120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b, `iter_cnt_o`=1.
- **Two iterations:** same inputs, c=2 → `dk_o`=ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43. The second request has `hmac_len_o`=32 and `hmac_msg_o`[511:256]=U_1.
- **Stub HMAC with random ready/valid stalls of 0–7 cycles:** c=5 → `dk_o` equals the XOR of the 5 stub responses and exactly 5 `hmac_v_o` transfers occur. `iter_i`=0 → exactly 1 transfer.
- **Salt-length boundaries:**
  - `salt_len_i`=51 → `hmac_len_o`=55, with INT(i) in bytes 51..54.
  - `salt_len_i`=52 → DONE with `err_o`=1, `dk_o`=0 and zero HMAC transfers.
- **Reset and back-pressure:**
  - `rst_ni` low in WAIT of iteration 3 → all handshake outputs go low in the next cycle, and `r_o`=1 after release.
  - `r_i` held low for 20 cycles in DONE → `v_o` and `dk_o` stay stable.
- **Back-to-back jobs:** jobs with i=1 then i=2 → two results in order, with the second accepted in the cycle after the first `r_i` transfer.
